// File: rtl/restoring_div_32_if.sv
// Start/busy/done handshake and operand/result bus for the sequential divider.
interface restoring_div_32_if;
  localparam int unsigned WIDTH = 32;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;

  modport master (output start, dividend, divisor, input busy, done, q, r, dbz);
  modport slave  (input start, dividend, divisor, output busy, done, q, r, dbz);
endinterface

// File: rtl/restoring_div_32.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro RESTORING_DIV_ZERO_CHECK_EN: divisor==0 short-circuits to DONE with dbz=1.

module full_sub_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        bin,
  output logic [31:0] d,
  output logic        bout
);
  // Borrow out is the sign of the 33-bit difference.
  assign {bout, d} = {1'b0, x} - {1'b0, y} - 33'(bin);
endmodule

module restoring_div_32 (
  input  logic               clk,
  input  logic               rst_n,
  restoring_div_32_if.slave  bus
);
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, dq_q, dq_d, dv_q, dv_d, qa_q, qa_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic             msb, sub_bout, qbit;
  logic [WIDTH-1:0] p_sh, sub_d, p_nx, qa_nx;

  // Trial subtraction on the shifted partial remainder; msb carries bit 32.
  assign {msb, p_sh} = {p_q, dq_q[WIDTH-1]};

  full_sub_32 u_sub (
    .x    (p_sh),
    .y    (dv_q),
    .bin  (1'b0),
    .d    (sub_d),
    .bout (sub_bout)
  );

  assign qbit  = msb | ~sub_bout;
  assign p_nx  = qbit ? sub_d : p_sh;
  assign qa_nx = {qa_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    dq_d    = dq_q;
    dv_d    = dv_q;
    qa_d    = qa_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dq_d  = bus.dividend;
          dv_d  = bus.divisor;
          p_d   = '0;
          qa_d  = '0;
          cnt_d = CNT_W'(WIDTH);
`ifdef RESTORING_DIV_ZERO_CHECK_EN
          if (bus.divisor == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            q_d     = '1;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = RUN;
          busy_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        p_d   = p_nx;
        dq_d  = {dq_q[WIDTH-2:0], 1'b0};
        qa_d  = qa_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          q_d     = qa_nx;
          r_d     = p_nx;
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      dq_q    <= '0;
      dv_q    <= '0;
      qa_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      dq_q    <= dq_d;
      dv_q    <= dv_d;
      qa_q    <= qa_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_restoring_div_32.sv
// Directed-vector bench for restoring_div_32: results, latency, busy length, abort and ignore cases.
module tb_restoring_div_32;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  restoring_div_32_if bus ();

  restoring_div_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One division; optional one-cycle stray start injected at RUN cycle inj_cyc.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int elat, input int ebusy, input int inj_cyc);
    int edges;
    int busy_cyc;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges    = 0;
    busy_cyc = 0;
    while (edges < 100) begin
      @(negedge clk);
      if (edges == inj_cyc) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd2;
      end else if (edges == inj_cyc + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) break;
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      edges++;
    end
    bus.start = 1'b0;
    check({tag, "_lat"},  32'(edges), 32'(elat));
    check({tag, "_busy"}, 32'(busy_cyc), 32'(ebusy));
    check({tag, "_q"},    bus.q, eq);
    check({tag, "_r"},    bus.r, er);
    check({tag, "_dbz"},  32'(bus.dbz), 32'(edbz));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"},  bus.q, eq);
  endtask

  initial begin
    bit seen;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_q",    bus.q, 32'd0);
    check("rst_r",    bus.r, 32'd0);
    check("rst_dbz",  32'(bus.dbz), 32'd0);
    rst_n = 1'b1;

    do_div("d59_11",   32'd59,        32'd11,        32'd5,         32'd4,          1'b0, 33, 32, -10);
    do_div("d11_59",   32'd11,        32'd59,        32'd0,         32'd11,         1'b0, 33, 32, -10);
    do_div("dmax_1",   32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,          1'b0, 33, 32, -10);
    do_div("d8000_3",  32'h80000000,  32'd3,         32'h2AAAAAAA,  32'd2,          1'b0, 33, 32, -10);
    do_div("dmsb",     32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE,   1'b0, 33, 32, -10);
`ifdef RESTORING_DIV_ZERO_CHECK_EN
    do_div("dbz",      32'd100,       32'd0,         32'hFFFFFFFF,  32'd100,        1'b1, 1,  0,  -10);
`else
    do_div("dbz",      32'd100,       32'd0,         32'hFFFFFFFF,  32'd100,        1'b0, 33, 32, -10);
`endif
    do_div("ignore",   32'd59,        32'd11,        32'd5,         32'd4,          1'b0, 33, 32, 5);

    // Reset mid-run: outputs clear immediately, no done afterwards.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd59;
    bus.divisor  = 32'd11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_q",    bus.q, 32'd0);
    check("abort_r",    bus.r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_div("after_rst", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33, 32, -10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
